// File: rtl/multi_freq_generator_if.sv
// Bus bundle for multi_freq_generator: configuration, control strobes and
// per-channel outputs. The master drives configuration/control and the
// generator (slave) drives the waveform and status outputs.
interface multi_freq_generator_if #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_burst;
    logic [NUM_CH-1:0]  start;
    logic [NUM_CH-1:0]  stop;
    logic               sync;
    logic [NUM_CH-1:0]  out_clk;
    logic [NUM_CH-1:0]  out_pulse;
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_high, cfg_burst, start, stop, sync,
        input  out_clk, out_pulse, busy, done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_high, cfg_burst, start, stop, sync,
        output out_clk, out_pulse, busy, done
    );
endinterface

// File: rtl/multi_freq_generator.sv
// Multi-channel programmable square-wave / pulse generator.
// Each channel has a shadow configuration (written any time) and an active
// configuration that is only refreshed on start and on every period wrap, so
// a reconfiguration never shortens or stretches the period in progress.
// A global sync strobe restarts the phase of every running channel.
module multi_freq_generator #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    multi_freq_generator_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0]   shadow_period_reg;
        logic [CNT_W-1:0]   shadow_high_reg;
        logic [BURST_W-1:0] shadow_burst_reg;
        logic [CNT_W-1:0]   period_reg;
        logic [CNT_W-1:0]   high_reg;
        logic [CNT_W-1:0]   counter_reg;
        logic [BURST_W-1:0] remaining_reg;
        state_t             state_reg;
        logic               out_clk_reg;
        logic               out_pulse_reg;
        logic               done_reg;
        logic [CNT_W-1:0]   period_eff;
        logic               wrap;

        // Periods below 2 are clamped when loaded so the active period is
        // always >= 2 and period_reg-1 can never underflow.
        assign period_eff = (shadow_period_reg < CNT_W'(2)) ? CNT_W'(2) : shadow_period_reg;
        assign wrap       = (counter_reg == period_reg - CNT_W'(1));

        // Shadow configuration: writes addressed to other (or nonexistent) channels are ignored.
        always_ff @(posedge sys_clk) begin
            if (reset) begin
                shadow_period_reg <= CNT_W'(2);
                shadow_high_reg   <= CNT_W'(1);
                shadow_burst_reg  <= '0;
            end else if (bus.cfg_we && (bus.cfg_ch == CH_W'(gi))) begin
                shadow_period_reg <= bus.cfg_period;
                shadow_high_reg   <= bus.cfg_high;
                shadow_burst_reg  <= bus.cfg_burst;
            end
        end

        // Channel FSM: counting, reload on wrap, burst accounting, registered outputs.
        always_ff @(posedge sys_clk) begin
            if (reset) begin
                state_reg     <= ST_IDLE;
                counter_reg   <= '0;
                period_reg    <= CNT_W'(2);
                high_reg      <= CNT_W'(1);
                remaining_reg <= '0;
                out_clk_reg   <= 1'b0;
                out_pulse_reg <= 1'b0;
                done_reg      <= 1'b0;
            end else begin
                // Outputs trail the counter by one cycle and drop to 0 once IDLE.
                out_clk_reg   <= (state_reg == ST_RUN) && (counter_reg < high_reg);
                out_pulse_reg <= (state_reg == ST_RUN) && (counter_reg == '0);
                done_reg      <= 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        counter_reg <= '0;
                        if (bus.start[gi] && !bus.stop[gi]) begin
                            state_reg     <= ST_RUN;
                            period_reg    <= period_eff;
                            high_reg      <= shadow_high_reg;
                            remaining_reg <= shadow_burst_reg;
                        end
                    end
                    ST_RUN: begin
                        if (bus.stop[gi]) begin
                            // Abort: no done pulse.
                            state_reg   <= ST_IDLE;
                            counter_reg <= '0;
                        end else if (wrap) begin
                            counter_reg <= '0;
                            period_reg  <= period_eff;
                            high_reg    <= shadow_high_reg;
                            if (remaining_reg != '0) begin
                                remaining_reg <= remaining_reg - BURST_W'(1);
                                if (remaining_reg == BURST_W'(1)) begin
                                    state_reg <= ST_IDLE;
                                    done_reg  <= 1'b1;
                                end
                            end
                        end else if (bus.sync) begin
                            // Phase restart only; configuration and burst count untouched.
                            counter_reg <= '0;
                        end else begin
                            counter_reg <= counter_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        counter_reg <= '0;
                    end
                endcase
            end
        end

        assign bus.out_clk[gi]   = out_clk_reg;
        assign bus.out_pulse[gi] = out_pulse_reg;
        assign bus.busy[gi]      = (state_reg == ST_RUN);
        assign bus.done[gi]      = done_reg;
    end
endmodule

// File: tb/tb_multi_freq_generator.sv
// Self-checking bench for multi_freq_generator: table-driven single-channel
// scenarios with a per-cycle scoreboard, plus hand-written sequences for
// shadow reload timing, sync alignment, stop and reset.
`timescale 1ns/1ps
module tb_multi_freq_generator;
    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic sys_clk = 1'b0;
    logic reset;

    always #5 sys_clk = ~sys_clk;

    multi_freq_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus();

    multi_freq_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        int         ch;
        logic [3:0] v;   // {done, busy, out_pulse, out_clk}
    } sb_t;

    typedef struct {
        int ch;
        int period;
        int high;
        int burst;
        int ncyc;
        int exp_pulses;
        int exp_highs;
        int exp_done_off;   // -1: no done expected in the window
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pulse_cnt[NUM_CH];
    int   high_cnt[NUM_CH];
    int   done_cnt[NUM_CH];
    int   last_done[NUM_CH];
    int   plog[NUM_CH][$];

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Closed-form expectation for a channel started at cycle T, d = c - T.
    function automatic logic [3:0] exp_at(int d, int p, int h, int b);
        int   pe;
        int   k;
        logic bz, dn, in_w, pl, ck;
        pe   = (p < 2) ? 2 : p;
        bz   = (d >= 1) && ((b == 0) || (d <= b * pe));
        dn   = (b != 0) && (d == 1 + b * pe);
        k    = d - 2;
        in_w = (d >= 2) && ((b == 0) || (k < b * pe));
        pl   = in_w && ((k % pe) == 0);
        ck   = in_w && ((k % pe) < h);
        return {dn, bz, pl, ck};
    endfunction

    // Sample on the falling edge, service the scoreboard, then advance one cycle.
    task automatic step();
        @(negedge sys_clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.out_pulse[c]) begin
                pulse_cnt[c]++;
                plog[c].push_back(cyc);
            end
            if (bus.out_clk[c]) high_cnt[c]++;
            if (bus.done[c]) begin
                done_cnt[c]++;
                last_done[c] = cyc;
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [3:0] act;
                act = {bus.done[sb[i].ch], bus.busy[sb[i].ch],
                       bus.out_pulse[sb[i].ch], bus.out_clk[sb[i].ch]};
                check($sformatf("sb_ch%0d_cyc%0d", sb[i].ch, sb[i].cyc), int'(act), int'(sb[i].v));
                sb.delete(i);
            end
        end
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.start      = '0;
        bus.stop       = '0;
        bus.sync       = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic cfg(int ch, int p, int h, int b);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_period = 16'(p);
        bus.cfg_high   = 16'(h);
        bus.cfg_burst  = 8'(b);
        step();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int T, S, p0, h0, dc0;

        for (int c = 0; c < NUM_CH; c++) begin
            pulse_cnt[c] = 0; high_cnt[c] = 0; done_cnt[c] = 0; last_done[c] = -1;
        end
        bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_high = '0; bus.cfg_burst = '0;

        //        ch period high burst ncyc pulses highs done_off
        vecs[0] = '{0, 10,  3,  0, 30, 3,  9, -1};
        vecs[1] = '{1,  4,  2,  3, 20, 3,  6, 13};
        vecs[2] = '{2,  0,  1,  0, 20, 9,  9, -1};
        vecs[3] = '{3,  5,  0,  2, 16, 2,  0, 11};
        vecs[4] = '{0, 10, 20,  1, 14, 1, 10, 11};
        vecs[5] = '{2,  1,  1,  2, 10, 2,  2,  5};

        do_reset();
        check("reset_outputs", int'({bus.out_clk, bus.out_pulse, bus.busy, bus.done}), 0);

        // Table-driven single-channel scenarios.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cfg(vecs[v].ch, vecs[v].period, vecs[v].high, vecs[v].burst);
            bus.start[vecs[v].ch] = 1'b1;
            T = cyc;
            for (int d = 0; d < vecs[v].ncyc; d++)
                sb.push_back('{T + d, vecs[v].ch, exp_at(d, vecs[v].period, vecs[v].high, vecs[v].burst)});
            p0  = pulse_cnt[vecs[v].ch];
            h0  = high_cnt[vecs[v].ch];
            dc0 = done_cnt[vecs[v].ch];
            step();
            bus.start = '0;
            wait_until(T + vecs[v].ncyc);
            check($sformatf("vec%0d_pulses", v), pulse_cnt[vecs[v].ch] - p0, vecs[v].exp_pulses);
            check($sformatf("vec%0d_highs", v), high_cnt[vecs[v].ch] - h0, vecs[v].exp_highs);
            check($sformatf("vec%0d_done_cnt", v), done_cnt[vecs[v].ch] - dc0, (vecs[v].exp_done_off >= 0) ? 1 : 0);
            if (vecs[v].exp_done_off >= 0)
                check($sformatf("vec%0d_done_time", v), last_done[vecs[v].ch] - T, vecs[v].exp_done_off);
            $display("vec %0d: ch=%0d period=%0d high=%0d burst=%0d pulses=%0d highs=%0d",
                     v, vecs[v].ch, vecs[v].period, vecs[v].high, vecs[v].burst,
                     pulse_cnt[vecs[v].ch] - p0, high_cnt[vecs[v].ch] - h0);
            bus.stop[vecs[v].ch] = 1'b1;
            step();
            bus.stop = '0;
            step();
        end

        // Shadow reload timing: writes at start and at a wrap are deferred one period;
        // a mid-period write takes effect at the next wrap; start while RUN is ignored.
        do_reset();
        cfg(0, 10, 3, 0);
        plog[0].delete();
        bus.start[0] = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_period = 16'd4;
        T = cyc;
        step();
        bus.start = '0; bus.cfg_we = 1'b0;
        wait_until(T + 5);
        bus.start[0] = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_period = 16'd6;
        step();
        bus.start = '0; bus.cfg_we = 1'b0;
        wait_until(T + 16);
        bus.cfg_we = 1'b1; bus.cfg_period = 16'd8;
        step();
        bus.cfg_we = 1'b0;
        wait_until(T + 36);
        check("shadow_npulse", plog[0].size(), 5);
        begin
            int exp_off[5] = '{2, 12, 18, 24, 32};
            for (int i = 0; i < 5 && i < plog[0].size(); i++)
                check($sformatf("shadow_pulse%0d", i), plog[0][i] - T, exp_off[i]);
        end
        $display("shadow seq: pulses=%0d", plog[0].size());

        // Sync alignment between two channels started 3 cycles apart.
        do_reset();
        cfg(0, 8, 4, 5);
        cfg(2, 8, 4, 0);
        plog[0].delete(); plog[2].delete();
        dc0 = done_cnt[0];
        bus.start[0] = 1'b1;
        T = cyc;
        step();
        bus.start = '0;
        wait_until(T + 3);
        bus.start[2] = 1'b1;
        step();
        bus.start = '0;
        S = T + 22;
        wait_until(S);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        wait_until(S + 30);
        check("sync_ch0_npulse", plog[0].size(), 6);
        check("sync_ch2_npulse", plog[2].size(), 7);
        for (int j = 0; j < 3; j++) begin
            if (plog[0].size() > 3 + j) check($sformatf("sync_ch0_p%0d", j), plog[0][3 + j] - S, 2 + 8 * j);
            if (plog[2].size() > 3 + j) check($sformatf("sync_ch2_p%0d", j), plog[2][3 + j] - S, 2 + 8 * j);
        end
        check("sync_done_cnt", done_cnt[0] - dc0, 1);
        check("sync_done_time", last_done[0] - S, 25);
        check("sync_busy_after", int'(bus.busy[0]), 0);
        $display("sync seq: ch0 pulses=%0d ch2 pulses=%0d", plog[0].size(), plog[2].size());

        // Stop/start together on an IDLE channel, stop mid-burst, defaults, reset mid-RUN.
        do_reset();
        bus.start[3] = 1'b1; bus.stop[3] = 1'b1;
        step();
        bus.start = '0; bus.stop = '0;
        check("ss_busy_c1", int'(bus.busy[3]), 0);
        step();
        check("ss_busy_c2", int'(bus.busy[3]), 0);
        check("ss_pulse_c2", int'(bus.out_pulse[3]), 0);

        cfg(1, 4, 2, 5);
        dc0 = done_cnt[1];
        bus.start[1] = 1'b1;
        T = cyc;
        step();
        bus.start = '0;
        wait_until(T + 6);
        bus.stop[1] = 1'b1;
        step();
        bus.stop = '0;
        check("stop_busy", int'(bus.busy[1]), 0);
        step();
        check("stop_outs", int'({bus.out_clk[1], bus.out_pulse[1]}), 0);
        wait_until(T + 30);
        check("stop_no_done", done_cnt[1] - dc0, 0);
        $display("stop seq: done pulses=%0d", done_cnt[1] - dc0);

        // Default shadow (period 2, high 1) after reset.
        bus.start[0] = 1'b1;
        T = cyc;
        for (int d = 0; d < 12; d++) sb.push_back('{T + d, 0, exp_at(d, 2, 1, 0)});
        step();
        bus.start = '0;
        wait_until(T + 12);
        cfg(0, 10, 3, 0);
        reset = 1'b1;
        step();
        check("rst_run_outs", int'({bus.out_clk, bus.out_pulse, bus.busy, bus.done}), 0);
        reset = 1'b0;
        bus.start[0] = 1'b1;
        T = cyc;
        for (int d = 0; d < 10; d++) sb.push_back('{T + d, 0, exp_at(d, 2, 1, 0)});
        step();
        bus.start = '0;
        wait_until(T + 10);
        check("sb_drained", sb.size(), 0);
        $display("reset seq: defaults restored check done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_freq_generator.md
Name: multi_freq_generator

Overview:
- Multi-channel, runtime-programmable successor to the single-channel frequency generator, used by the IR driver for carrier and bit-timing generation.
- Each of NUM_CH channels produces a square wave with programmable period and high time, plus a one-cycle pulse per period.
- Channels run continuously or for a fixed burst of periods.
- Configuration is double-buffered, so updates never glitch mid-period. A global sync strobe phase-aligns all running channels.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
CNT_W, 16, width of period/high counters
BURST_W, 8, width of burst-length field

Ports:
sys_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  write shadow config of channel cfg_ch
cfg_ch  in  max(1,$clog2(NUM_CH))  channel select for cfg_we
cfg_period  in  CNT_W  period in sys_clk cycles
cfg_high  in  CNT_W  cycles out_clk is high per period
cfg_burst  in  BURST_W  periods per burst; 0 = continuous
start  in  NUM_CH  per-channel start request
stop  in  NUM_CH  per-channel abort request
sync  in  1  restart phase of all running channels
out_clk  out  NUM_CH  square-wave outputs
out_pulse  out  NUM_CH  one-cycle pulse at start of each period
busy  out  NUM_CH  channel in RUN
done  out  NUM_CH  one-cycle pulse when a burst completes

Behaviour:
Reset:
- All channels go to IDLE. counter=0. All outputs 0.
- Shadow registers reset to period=2, high=1, burst=0.

Configuration:
- cfg_we writes the shadow registers of cfg_ch at the clock edge.
- cfg_ch >= NUM_CH is ignored.
- Active registers are loaded from shadow only on start from IDLE and on each period wrap in RUN.
- A shadow write in the same cycle as start or wrap is not seen; the previous shadow value is used.

Effective values:
- Period values 0 or 1 are treated as 2.
- high=0 gives out_clk constantly 0.
- high >= period gives out_clk constantly 1.

Per-channel FSM, IDLE -> RUN:
- start[i] in IDLE loads the active registers and sets remaining=burst.
- The channel enters RUN with counter=0. busy=1 from the next cycle.
- start[i] while in RUN is ignored.

RUN, counting:
- Each cycle counter increments.
- At counter==period_a-1 the channel wraps: counter goes to 0, active registers reload, and if remaining!=0 then remaining decrements.

Burst end:
- At a wrap with remaining==1 the channel returns to IDLE and done[i]=1 for one cycle.
- done coincides with the first IDLE cycle of busy.
- Continuous mode (burst=0) never ends on its own.

Outputs (registered, one cycle behind counter):
- out_clk <= RUN && counter < high_a
- out_pulse <= RUN && counter==0
- In IDLE both outputs are 0 the cycle after leaving RUN.
- Start at cycle T gives first out_pulse at T+2, then every period_a cycles.

stop[i]:
- In RUN the channel goes to IDLE next cycle without a done pulse.
- stop and start in the same cycle: stop wins and the channel stays or goes IDLE.
- stop in IDLE has no effect.

sync:
- Every RUN channel takes counter <= 0. There is no reload and no burst decrement unless a wrap occurs in the same cycle, in which case the normal wrap processing also happens.
- IDLE channels are unaffected.

Reset during RUN:
- Immediate return to reset state. No done pulse.
- Shadow values revert to their reset defaults.

Arithmetic:
- Compare logic must not overflow at period = 2^CNT_W-1.
- All channels are independent except for sync.

Test Plan:
1. Reset, configure ch0 period=10, high=3, burst=0, start[0] at T → out_pulse[0] at T+2, T+12, T+22; out_clk[0] high 3 of every 10 cycles; busy[0]=1 from T+1.
2. ch1 period=4, high=2, burst=3, start → exactly 3 out_pulses, then done[1] for one cycle 12 cycles after busy rises; busy[1]=0 afterwards.
3. ch0 running period=10; write period=6 mid-period → current period completes at 10 cycles, following periods are 6; no short or long glitch.
4. ch0 period=8 and ch2 period=8 started 3 cycles apart, then sync → both out_pulse asserted in the same cycle thereafter; burst counts unchanged.
5. Edge values: period=0 → behaves as 2; high=0 → out_clk stays 0 with pulses present; high=20 with period=10 → out_clk stays 1.
6. stop and start same cycle on IDLE ch3 → stays IDLE. stop mid-burst → IDLE next cycle, no done. reset mid-RUN → all outputs 0 next cycle.
